// File: rtl/xbar_req_router.sv
// Request crossbar: steers NUM_CH cache channels to NUM_BANK htu banks through
// per-bank round-robin arbiters and one-entry registered output slots.
module xbar_req_router #(
  parameter  int NUM_CH    = 3,
  parameter  int NUM_BANK  = 4,
  parameter  int ADDR_W    = 28,
  parameter  int OP_W      = 2,
  parameter  int BANK_LSB  = 0,
  parameter  int HASH_MODE = 0,
  localparam int BANK_W    = $clog2(NUM_BANK),
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUM_CH-1:0]          ch_req_valid_i,
  output logic [NUM_CH-1:0]          ch_req_allowIn_o,
  input  logic [NUM_CH*OP_W-1:0]     ch_req_op_i,
  input  logic [NUM_CH*ADDR_W-1:0]   ch_req_addr_i,
  output logic [NUM_BANK-1:0]        bank_valid_o,
  input  logic [NUM_BANK-1:0]        bank_allowIn_i,
  output logic [NUM_BANK*CH_W-1:0]   bank_ch_id_o,
  output logic [NUM_BANK*OP_W-1:0]   bank_opcode_o,
  output logic [NUM_BANK*ADDR_W-1:0] bank_addr_o
);

  if (BANK_LSB + 2 * BANK_W > ADDR_W) begin : g_bad_cfg
    $error("xbar_req_router: BANK_LSB + 2*BANK_W exceeds ADDR_W");
  end

  logic [NUM_CH-1:0][BANK_W-1:0]   sel;
  logic [NUM_BANK-1:0]             found;
  logic [NUM_BANK-1:0][CH_W-1:0]   gnt_ch;
  logic [NUM_BANK-1:0]             slot_rdy;
  logic [NUM_BANK-1:0]             xfer;

  logic [NUM_BANK-1:0]             valid_q, valid_d;
  logic [NUM_BANK-1:0][CH_W-1:0]   ch_q, ch_d;
  logic [NUM_BANK-1:0][OP_W-1:0]   op_q, op_d;
  logic [NUM_BANK-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic [NUM_BANK-1:0][CH_W-1:0]   ptr_q, ptr_d;

  always_comb begin
    sel = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sel[c] = ch_req_addr_i[c*ADDR_W + BANK_LSB +: BANK_W];
      if (HASH_MODE != 0)
        sel[c] = sel[c] ^ ch_req_addr_i[c*ADDR_W + BANK_LSB + BANK_W +: BANK_W];
    end
  end

  // Cyclic search from each bank's pointer; first requester found wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = '0;
    gnt_ch = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = (int'(ptr_q[b]) + k) % NUM_CH;
        if (!found[b] && ch_req_valid_i[idx] && (sel[idx] == BANK_W'(b))) begin
          found[b]  = 1'b1;
          gnt_ch[b] = CH_W'(idx);
        end
      end
    end
  end

  // A slot being drained this cycle may be refilled in the same cycle.
  assign slot_rdy = ~valid_q | bank_allowIn_i;
  assign xfer     = found & slot_rdy & {NUM_BANK{~rst_i}};

  always_comb begin
    ch_req_allowIn_o = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (xfer[b]) ch_req_allowIn_o[gnt_ch[b]] = 1'b1;
    end
  end

  always_comb begin
    valid_d = valid_q;
    ch_d    = ch_q;
    op_d    = op_q;
    addr_d  = addr_q;
    ptr_d   = ptr_q;
    for (int b = 0; b < NUM_BANK; b++) begin
      if (xfer[b]) begin
        valid_d[b] = 1'b1;
        ch_d[b]    = gnt_ch[b];
        op_d[b]    = ch_req_op_i[int'(gnt_ch[b])*OP_W +: OP_W];
        addr_d[b]  = ch_req_addr_i[int'(gnt_ch[b])*ADDR_W +: ADDR_W];
        ptr_d[b]   = (int'(gnt_ch[b]) == NUM_CH - 1) ? '0 : gnt_ch[b] + CH_W'(1);
      end else if (bank_allowIn_i[b]) begin
        valid_d[b] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= '0;
      ch_q    <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      ptr_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ch_q    <= ch_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bank_valid_o  = valid_q;
  assign bank_ch_id_o  = ch_q;
  assign bank_opcode_o = op_q;
  assign bank_addr_o   = addr_q;

endmodule

// File: tb/tb_xbar_req_router.sv
// Bench for xbar_req_router: directed vectors, corner sequences and a
// randomized run against a behavioural slot/pointer model.
module tb_xbar_req_router;

  localparam int NC = 3;
  localparam int NB = 4;
  localparam int AW = 28;
  localparam int OW = 2;
  localparam int CW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [NC-1:0]  valid;
  logic [NC-1:0]  allow, h_allow;
  logic [NC*OW-1:0] op;
  logic [NC*AW-1:0] addr;
  logic [NB-1:0]  bv, h_bv;
  logic [NB-1:0]  ballow;
  logic [NB*CW-1:0] bch, h_bch;
  logic [NB*OW-1:0] bop, h_bop;
  logic [NB*AW-1:0] baddr, h_baddr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xbar_req_router dut (
    .clk_i(clk), .rst_i(rst), .ch_req_valid_i(valid), .ch_req_allowIn_o(allow),
    .ch_req_op_i(op), .ch_req_addr_i(addr), .bank_valid_o(bv),
    .bank_allowIn_i(ballow), .bank_ch_id_o(bch), .bank_opcode_o(bop),
    .bank_addr_o(baddr)
  );

  xbar_req_router #(.HASH_MODE(1)) dut_hash (
    .clk_i(clk), .rst_i(rst), .ch_req_valid_i(valid), .ch_req_allowIn_o(h_allow),
    .ch_req_op_i(op), .ch_req_addr_i(addr), .bank_valid_o(h_bv),
    .bank_allowIn_i(ballow), .bank_ch_id_o(h_bch), .bank_opcode_o(h_bop),
    .bank_addr_o(h_baddr)
  );

  typedef struct {
    logic [2:0]  v;
    logic [27:0] a0, a1, a2;
    logic [2:0]  exp_allow;
    logic [3:0]  exp_bv;
  } vec_t;

  vec_t vecs[6];

  // reference model state
  bit          m_sv[NB];
  int          m_ch[NB];
  int          m_op[NB];
  logic [27:0] m_addr[NB];
  int          m_ptr[NB];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = '0; ballow = '0; op = '0; addr = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic set_addr(input logic [27:0] a0, input logic [27:0] a1, input logic [27:0] a2);
    addr = {a2, a1, a0};
  endtask

  function automatic int bank_of(input logic [27:0] a);
    int unsigned x;
    x = a;
    return int'(x % NB);
  endfunction

  // Expected accept vector from model state and current inputs.
  function automatic logic [NC-1:0] model_allow(output int gch[NB], output bit gok[NB]);
    logic [NC-1:0] r;
    r = '0;
    for (int b = 0; b < NB; b++) begin
      gok[b] = 0;
      gch[b] = 0;
      for (int k = 0; k < NC; k++) begin
        int c;
        c = (m_ptr[b] + k) % NC;
        if (!gok[b] && valid[c] && bank_of(addr[c*AW +: AW]) == b) begin
          gok[b] = 1;
          gch[b] = c;
        end
      end
      if (gok[b] && (!m_sv[b] || ballow[b]) && !rst) r[gch[b]] = 1'b1;
    end
    return r;
  endfunction

  task automatic model_clear();
    for (int b = 0; b < NB; b++) begin
      m_sv[b] = 0; m_ch[b] = 0; m_op[b] = 0; m_addr[b] = '0; m_ptr[b] = 0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{3'b001, 28'h12, 28'h0, 28'h0, 3'b001, 4'b0100};
    vecs[1] = '{3'b111, 28'h0,  28'h1, 28'h3, 3'b111, 4'b1011};
    vecs[2] = '{3'b111, 28'h1,  28'h5, 28'h9, 3'b001, 4'b0010};
    vecs[3] = '{3'b110, 28'h0,  28'h2, 28'h6, 3'b010, 4'b0100};
    vecs[4] = '{3'b000, 28'h1,  28'h2, 28'h3, 3'b000, 4'b0000};
    vecs[5] = '{3'b100, 28'h0,  28'h0, 28'h7, 3'b100, 4'b1000};

    rst = 1'b1; valid = '0; ballow = '0; op = '0; addr = '0;
    tick(); tick();
    rst = 1'b0;
    #2;
    chk("reset_bank_valid", 64'(bv), 64'h0);
    chk("reset_bank_addr", 64'(baddr[27:0]), 64'h0);

    for (int i = 0; i < 6; i++) begin
      do_reset();
      valid = vecs[i].v; ballow = 4'b0100;
      set_addr(vecs[i].a0, vecs[i].a1, vecs[i].a2);
      #2;
      chk($sformatf("vec%0d_allow", i), 64'(allow), 64'(vecs[i].exp_allow));
      tick();
      valid = '0; ballow = '0;
      #2;
      chk($sformatf("vec%0d_bank_valid", i), 64'(bv), 64'(vecs[i].exp_bv));
    end
    chk("vec0_like_ch_id", 64'(bch[3*CW +: CW]), 64'h2);

    // first-request latency and payload
    do_reset();
    valid = 3'b001; ballow = 4'b0100; op = 6'b000011;
    set_addr(28'h0000012, 28'h0, 28'h0);
    #2;
    chk("lat_allow", 64'(allow), 64'h1);
    tick();
    valid = '0;
    #2;
    chk("lat_bank_valid", 64'(bv), 64'h4);
    chk("lat_ch_id", 64'(bch[2*CW +: CW]), 64'h0);
    chk("lat_addr", 64'(baddr[2*AW +: AW]), 64'h12);
    chk("lat_op", 64'(bop[2*OW +: OW]), 64'h3);

    // round robin on bank1
    do_reset();
    valid = 3'b111; ballow = 4'b1111;
    set_addr(28'h1, 28'h5, 28'h9);
    for (int k = 0; k < 4; k++) begin
      #2;
      chk($sformatf("rr_allow%0d", k), 64'(allow), 64'(1 << (k % 3)));
      if (k > 0) chk($sformatf("rr_chid%0d", k), 64'(bch[1*CW +: CW]), 64'((k - 1) % 3));
      tick();
    end
    #2;
    chk("rr_chid_last", 64'(bch[1*CW +: CW]), 64'h0);

    // stall on bank3 then pipe-through
    do_reset();
    valid = 3'b001; ballow = '0;
    set_addr(28'h3, 28'h7, 28'h0);
    tick();
    valid = 3'b010;
    for (int k = 0; k < 5; k++) begin
      #2;
      chk("stall_allow", 64'(allow), 64'h0);
      chk("stall_bv3", 64'(bv[3]), 64'h1);
      chk("stall_chid", 64'(bch[3*CW +: CW]), 64'h0);
      chk("stall_addr", 64'(baddr[3*AW +: AW]), 64'h3);
      tick();
    end
    ballow = 4'b1000;
    #2;
    chk("pipe_allow", 64'(allow), 64'h2);
    tick();
    valid = '0; ballow = '0;
    #2;
    chk("pipe_bv", 64'(bv), 64'h8);
    chk("pipe_chid", 64'(bch[3*CW +: CW]), 64'h1);
    chk("pipe_addr", 64'(baddr[3*AW +: AW]), 64'h7);

    // hashed routing
    do_reset();
    valid = 3'b001; ballow = '0;
    set_addr(28'h35, 28'h0, 28'h0);
    #2;
    chk("hash_allow", 64'(h_allow), 64'h1);
    tick();
    valid = '0;
    #2;
    chk("hash_bv", 64'(h_bv), 64'h1);
    chk("direct_bv", 64'(bv), 64'h2);

    // reset mid-operation
    do_reset();
    valid = 3'b111; ballow = '0;
    set_addr(28'h1, 28'h0, 28'h2);
    tick();
    #2;
    chk("mid_fill_bv", 64'(bv), 64'h7);
    set_addr(28'h1, 28'h5, 28'h9);
    rst = 1'b1;
    #2;
    chk("mid_rst_allow", 64'(allow), 64'h0);
    tick();
    rst = 1'b0;
    #2;
    chk("mid_rst_bv", 64'(bv), 64'h0);
    chk("mid_restart_allow", 64'(allow), 64'h1);

    // randomized run against the model
    do_reset();
    model_clear();
    for (int n = 0; n < 2000; n++) begin
      int  gch[NB];
      bit  gok[NB];
      logic [NC-1:0] ea;
      rst    = ($urandom_range(0, 99) == 0);
      valid  = NC'($urandom);
      ballow = NB'($urandom);
      op     = NC*OW'($urandom);
      for (int c = 0; c < NC; c++) addr[c*AW +: AW] = AW'($urandom);
      #2;
      ea = model_allow(gch, gok);
      chk("rnd_allow", 64'(allow), 64'(ea));
      for (int b = 0; b < NB; b++) begin
        chk("rnd_bv", 64'(bv[b]), 64'(m_sv[b]));
        if (m_sv[b]) begin
          chk("rnd_chid", 64'(bch[b*CW +: CW]), 64'(m_ch[b]));
          chk("rnd_op", 64'(bop[b*OW +: OW]), 64'(m_op[b]));
          chk("rnd_addr", 64'(baddr[b*AW +: AW]), 64'(m_addr[b]));
        end
      end
      tick();
      if (rst) begin
        model_clear();
      end else begin
        for (int b = 0; b < NB; b++) begin
          if (gok[b] && (!m_sv[b] || ballow[b])) begin
            m_sv[b]   = 1;
            m_ch[b]   = gch[b];
            m_op[b]   = int'(op[gch[b]*OW +: OW]);
            m_addr[b] = addr[gch[b]*AW +: AW];
            m_ptr[b]  = (gch[b] + 1) % NC;
          end else if (ballow[b]) begin
            m_sv[b] = 0;
          end
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
